// File: rtl/packet_release_ctrl_pkg.sv
// Shared router constants for the output-port release controller: port count, flit width,
// port indices and the per-port FSM state encodings.
package packet_release_ctrl_pkg;

  localparam int NPORT    = 5;
  localparam int TAM_FLIT = 8;
  localparam int NP_REGF  = NPORT * TAM_FLIT;

  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  localparam logic [1:0] PRC_FREE    = 2'd0;
  localparam logic [1:0] PRC_HEADER  = 2'd1;
  localparam logic [1:0] PRC_SIZE    = 2'd2;
  localparam logic [1:0] PRC_PAYLOAD = 2'd3;

  typedef struct packed {
    logic                tx;
    logic                credit;
    logic [TAM_FLIT-1:0] data;
  } port_in_t;

  function automatic logic grant_in_range(input logic [2:0] idx);
    return idx < 3'(NPORT);
  endfunction

endpackage

// File: rtl/packet_release_ctrl_tracker.sv
// One output port: header/size/payload FSM, payload counter and (with PRC_WATCHDOG_EN)
// an idle watchdog that forces the port free.
module port_packet_tracker
  import packet_release_ctrl_pkg::*;
#(
  parameter int WDOG_CYCLES = 255
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_grant,
  input  port_in_t i_port,
  output logic     o_free,
  output logic     o_release,
  output logic     o_timeout
);

  logic [1:0]          state, state_nxt, state_d;
  logic [TAM_FLIT-1:0] cnt, cnt_nxt;
  logic                xfer, done, wd_hit;

  assign xfer   = i_port.tx & i_port.credit;
  assign o_free = (state == PRC_FREE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    case (state)
      PRC_FREE:   if (i_grant) state_nxt = PRC_HEADER;
      PRC_HEADER: if (xfer) state_nxt = PRC_SIZE;
      PRC_SIZE: begin
        if (xfer) begin
          cnt_nxt = i_port.data;
          if (i_port.data == '0) begin
            state_nxt = PRC_FREE;
            done      = 1'b1;
          end else begin
            state_nxt = PRC_PAYLOAD;
          end
        end
      end
      PRC_PAYLOAD: begin
        if (xfer) begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == TAM_FLIT'(1)) begin
            state_nxt = PRC_FREE;
            done      = 1'b1;
          end
        end
      end
      default: state_nxt = PRC_FREE;
    endcase
  end

`ifdef PRC_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] idle;
  logic           tmo;

  // Hit on the cycle the idle count would reach WDOG_CYCLES; a transfer that cycle rescues the port.
  assign wd_hit = (state != PRC_FREE) && !xfer && (idle == WDW'(WDOG_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idle <= '0;
      tmo  <= 1'b0;
    end else begin
      if (state == PRC_FREE || xfer || wd_hit) idle <= '0;
      else                                     idle <= idle + 1'b1;
      if (wd_hit) tmo <= 1'b1;
    end
  end

  assign o_timeout = tmo;
`else
  assign wd_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign state_d = wd_hit ? PRC_FREE : state_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= PRC_FREE;
      cnt       <= '0;
      o_release <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_nxt;
      o_release <= done | wd_hit;
    end
  end

endmodule

// File: rtl/packet_release_ctrl.sv
// Output-port allocation tracker: one port_packet_tracker per output, plus sticky grant-error
// detection. Optional per-port watchdog compiled under PRC_WATCHDOG_EN.
module packet_release_ctrl
  import packet_release_ctrl_pkg::*;
#(
  parameter int WDOG_CYCLES = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_grant,
  input  logic [2:0]         i_grant_out,
  input  logic [NPORT-1:0]   i_tx,
  input  logic [NPORT-1:0]   i_credit,
  input  logic [NP_REGF-1:0] i_data,
  output logic [NPORT-1:0]   o_free,
  output logic [NPORT-1:0]   o_release,
  output logic               o_grant_err,
  output logic [NPORT-1:0]   o_timeout
);

  logic [NPORT-1:0][TAM_FLIT-1:0] data_v;
  logic [NPORT-1:0]               grant_hit;
  port_in_t [NPORT-1:0]           pin;
  logic                           err_now;

  assign data_v = i_data;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    assign grant_hit[p] = i_grant && (i_grant_out == 3'(p));
    assign pin[p]       = '{tx: i_tx[p], credit: i_credit[p], data: data_v[p]};

    port_packet_tracker #(.WDOG_CYCLES(WDOG_CYCLES)) u_trk (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_grant   (grant_hit[p]),
      .i_port    (pin[p]),
      .o_free    (o_free[p]),
      .o_release (o_release[p]),
      .o_timeout (o_timeout[p])
    );
  end

  // A port finishing its packet this cycle is still busy, so a grant to it is an error.
  assign err_now = i_grant && (!grant_in_range(i_grant_out) || |(grant_hit & ~o_free));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        o_grant_err <= 1'b0;
    else if (err_now) o_grant_err <= 1'b1;
  end

endmodule
